// File: rtl/noc_flit_injector.sv
// Credit-flow-controlled flit injector: a registered FIFO between the flitizer and the router's local input port.
// Optional packet counter is enabled by defining NOC_INJECTOR_PKT_COUNT_EN.
module noc_flit_injector #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CREDITS    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [FLIT_WIDTH-1:0] in_flit_i,
    input  logic [1:0]            in_type_i,
    output logic                  out_valid_o,
    output logic [FLIT_WIDTH-1:0] out_flit_o,
    output logic [1:0]            out_type_o,
    input  logic                  credit_return_i,
    output logic                  framing_err_o,
    output logic                  busy_o,
    output logic [15:0]           pkt_count_o
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] CRED_INIT = 4'(CREDITS);

    localparam logic [0:0] IN_IDLE = 1'b0;
    localparam logic [0:0] IN_PKT  = 1'b1;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    logic [FLIT_WIDTH-1:0] flit_mem_q [DEPTH];
    logic [1:0]            type_mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic                  empty, full, push, pop;
    logic [FLIT_WIDTH-1:0] head_flit;
    logic [1:0]            head_type;

    logic [3:0]            credits_q, credits_d;
    logic [FLIT_WIDTH-1:0] last_flit_q;
    logic [1:0]            last_type_q;
    logic [0:0]            state_q, state_d;
    logic                  err_q, err_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push      = in_valid_i && !full;
    assign pop       = !empty && (credits_q != 4'd0);
    assign head_flit = flit_mem_q[rd_ptr_q[AW-1:0]];
    assign head_type = type_mem_q[rd_ptr_q[AW-1:0]];

    assign in_ready_o    = !full;
    assign out_valid_o   = pop;
    assign out_flit_o    = pop ? head_flit : last_flit_q;
    assign out_type_o    = pop ? head_type : last_type_q;
    assign framing_err_o = err_q;
    assign busy_o        = !empty || (state_q == IN_PKT);

    always_ff @(posedge clk_i) begin
        if (push) begin
            flit_mem_q[wr_ptr_q[AW-1:0]] <= in_flit_i;
            type_mem_q[wr_ptr_q[AW-1:0]] <= in_type_i;
        end
    end

    // A simultaneous send and return cancel; returns beyond the initial count are dropped.
    always_comb begin
        credits_d = credits_q;
        if (pop && !credit_return_i) begin
            credits_d = credits_q - 4'd1;
        end else if (!pop && credit_return_i && (credits_q != CRED_INIT)) begin
            credits_d = credits_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (push) begin
            case (in_type_i)
                T_HEAD: begin
                    if (state_q == IN_PKT) err_d = 1'b1;
                    state_d = IN_PKT;
                end
                T_BODY: begin
                    if (state_q == IN_IDLE) err_d = 1'b1;
                end
                T_TAIL: begin
                    if (state_q == IN_IDLE) err_d = 1'b1;
                    state_d = IN_IDLE;
                end
                default: begin
                    if (state_q == IN_PKT) err_d = 1'b1;
                    state_d = IN_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            credits_q   <= CRED_INIT;
            last_flit_q <= '0;
            last_type_q <= '0;
            state_q     <= IN_IDLE;
            err_q       <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                last_flit_q <= head_flit;
                last_type_q <= head_type;
            end
            credits_q <= credits_d;
            state_q   <= state_d;
            err_q     <= err_d;
        end
    end

`ifdef NOC_INJECTOR_PKT_COUNT_EN
    logic [15:0] pkt_count_q;

    // Tail and head_tail both have type bit 1 set, marking the end of a packet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_count_q <= '0;
        end else if (pop && head_type[1]) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign pkt_count_o = pkt_count_q;
`else
    assign pkt_count_o = '0;
`endif

endmodule
